// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

    localparam int DEF_LS_STREAK = 4;
    localparam int DEF_TIMEOUT   = 15;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module mem_timeout_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto a single-outstanding
// memory port, with LSU priority bounded by a streak limit and a WAIT timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LS_STREAK = DEF_LS_STREAK,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        bus_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int SW = cnt_width(LS_STREAK);
    localparam int CW = cnt_width(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK);
    // Loaded with TIMEOUT-1 so the final permitted WAIT cycle sees expiry.
    localparam logic [CW-1:0] TO_LOAD    = CW'(TIMEOUT - 1);

    state_e        state_q;
    gnt_e          gnt_q;
    logic [SW-1:0] streak_q;
    logic          if_ready_q, ls_ready_q, bus_err_q, mem_en_q, mem_we_q;
    logic [31:0]   if_rdata_q, ls_rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_wstrb_q;

    logic ls_wins;
    logic to_load, to_dec, to_expired;

    assign ls_wins = ls_req && !(if_req && (streak_q == STREAK_MAX));
    assign to_load = (state_q == ST_ISSUE);
    assign to_dec  = (state_q == ST_WAIT) && !mem_ack;

    mem_timeout_ctr #(
        .WIDTH (CW)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .dec_i      (to_dec),
        .expired_o  (to_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            streak_q    <= '0;
            if_ready_q  <= 1'b0;
            ls_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            mem_en_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        state_q  <= ST_ISSUE;
                        mem_en_q <= 1'b1;
                        if (ls_wins) begin
                            gnt_q       <= GNT_LS;
                            mem_we_q    <= ls_we;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= ls_wdata;
                            mem_wstrb_q <= ls_wstrb;
                            if (!if_req) begin
                                streak_q <= '0;
                            end else if (streak_q != STREAK_MAX) begin
                                streak_q <= streak_q + SW'(1);
                            end
                        end else begin
                            gnt_q       <= GNT_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= 4'h0;
                            streak_q    <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack arriving on the last allowed cycle still wins over expiry.
                    if (mem_ack || to_expired) begin
                        state_q   <= ST_RESP;
                        bus_err_q <= !mem_ack;
                        if (gnt_q == GNT_LS) begin
                            ls_ready_q <= 1'b1;
                            ls_rdata_q <= (mem_ack && !mem_we_q) ? mem_rdata : 32'h0;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_rdata : 32'h0;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign ls_ready  = ls_ready_q;
    assign ls_rdata  = ls_rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_wstrb = '0;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        bus_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wstrb  (ls_wstrb),
        .ls_ready  (ls_ready),
        .ls_rdata  (ls_rdata),
        .bus_err   (bus_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({if_ready, ls_ready, bus_err, mem_en, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {if_ready, ls_ready, bus_err, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h wstrb=%h ifr=%h lsr=%h want all 0",
                     mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata);
        end
        rst = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        tick();                                   // cycle 1: ISSUE
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL fetch_issue got en=%b addr=%h we=%b wstrb=%h want 1/00000100/0/0",
                     mem_en, mem_addr, mem_we, mem_wstrb);
        end
        tick();                                   // cycle 2: WAIT
        checks++;
        if (mem_en !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait1 got en=%b rdy=%b want 0/0", mem_en, if_ready);
        end
        tick();                                   // cycle 3: ack
        mem_ack = 1'b1; mem_rdata = 32'h13;
        tick();                                   // cycle 4: RESP
        mem_ack = 1'b0; mem_rdata = '0;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h13 || bus_err !== 1'b0 || ls_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp got rdy=%b rdata=%h err=%b lsrdy=%b want 1/00000013/0/0",
                     if_ready, if_rdata, bus_err, ls_ready);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_pulse got rdy=%b rdata=%h want 0/0", if_ready, if_rdata);
        end
        $display("txn fetch addr=00000100 rdata=%h", 32'h13);
    endtask

    task automatic test_both_request();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL both_first got en=%b addr=%h we=%b want 1/00002000/0", mem_en, mem_addr, mem_we);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA0001;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'hAAAA0001 || if_ready !== 1'b0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL both_ls_resp got lsrdy=%b lsr=%h ifrdy=%b ifr=%h want 1/aaaa0001/0/0",
                     ls_ready, ls_rdata, if_ready, if_rdata);
        end
        $display("txn both: load 00002000 served first");
        ls_req = 1'b0;
        tick();                                   // IDLE
        tick();                                   // ISSUE for fetch
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h104) begin
            errors++;
            $display("FAIL both_second got en=%b addr=%h want 1/00000104", mem_en, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000BEEF;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0000BEEF || ls_ready !== 1'b0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL both_if_resp got ifrdy=%b ifr=%h lsrdy=%b lsr=%h want 1/0000beef/0/0",
                     if_ready, if_rdata, ls_ready, ls_rdata);
        end
        $display("txn both: fetch 00000104 served second");
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_streak();
        logic [31:0] exp_addr [6];
        exp_addr = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h200, 32'h4000};
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4000;
        if_req = 1'b1; if_addr = 32'h200;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== exp_addr[n]) begin
                errors++;
                $display("FAIL streak_grant%0d got en=%b addr=%h want 1/%h", n, mem_en, mem_addr, exp_addr[n]);
            end
            tick();
            mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(n);
            tick();
            mem_ack = 1'b0;
            checks++;
            if ((exp_addr[n] == 32'h200 && (if_ready !== 1'b1 || ls_ready !== 1'b0)) ||
                (exp_addr[n] != 32'h200 && (ls_ready !== 1'b1 || if_ready !== 1'b0))) begin
                errors++;
                $display("FAIL streak_ready%0d got ifrdy=%b lsrdy=%b for addr %h", n, if_ready, ls_ready, exp_addr[n]);
            end
            $display("txn streak access %0d addr=%h", n, mem_addr);
            if (n == 5) begin
                ls_req = 1'b0; if_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'h3;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 ||
            mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'h3) begin
            errors++;
            $display("FAIL store_issue got en=%b we=%b addr=%h wdata=%h wstrb=%h want 1/1/00003000/deadbeef/3",
                     mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_wstrb !== 4'h3 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL store_hold got we=%b wstrb=%h en=%b want 1/3/0", mem_we, mem_wstrb, mem_en);
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL store_resp got rdy=%b rdata=%h err=%b want 1/0/0", ls_ready, ls_rdata, bus_err);
        end
        $display("txn store addr=00003000 data=deadbeef strb=3");
        ls_req = 1'b0; ls_we = 1'b0; ls_wstrb = 4'h0;
        tick();
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h5000;
        tick();                                   // ISSUE
        for (int w = 1; w <= 15; w++) begin
            tick();                               // WAIT cycle w
            if (ls_ready !== 1'b0 || bus_err !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_early got ready/err during 15 WAIT cycles want none");
        end
        tick();                                   // RESP
        checks++;
        if (ls_ready !== 1'b1 || bus_err !== 1'b1 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp got rdy=%b err=%b rdata=%h want 1/1/0", ls_ready, bus_err, ls_rdata);
        end
        $display("txn timeout addr=00005000 bus_err=%b", bus_err);
        ls_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();                                   // IDLE; late ack was ignored
        mem_ack = 1'b0;
        checks++;
        if (ls_ready !== 1'b0 || bus_err !== 1'b0 || mem_en !== 1'b0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_late_ack got rdy=%b err=%b en=%b rdata=%h want 0/0/0/0",
                     ls_ready, bus_err, mem_en, ls_rdata);
        end
        ls_req = 1'b1; ls_addr = 32'h5004;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'h55AA55AA || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover got rdy=%b rdata=%h err=%b want 1/55aa55aa/0",
                     ls_ready, ls_rdata, bus_err);
        end
        $display("txn load addr=00005004 after timeout");
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bit stray;
        stray = 1'b0;
        if_req = 1'b1; if_addr = 32'h600;
        tick();                                   // ISSUE
        tick();                                   // WAIT
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({if_ready, ls_ready, bus_err, mem_en, mem_we} !== 5'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got flags=%b addr=%h want 00000/0",
                     {if_ready, ls_ready, bus_err, mem_en, mem_we}, mem_addr);
        end
        if_req = 1'b0;
        mem_ack = 1'b1;                           // stale ack while in reset
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if_ready !== 1'b0 || mem_en !== 1'b0) stray = 1'b1;
        end
        rst = 1'b1;
        tick();                                   // stale ack seen in IDLE
        mem_ack = 1'b0;
        if (if_ready !== 1'b0) stray = 1'b1;
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rstmid_no_ready got ready or mem_en pulse around reset want none");
        end
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h700) begin
            errors++;
            $display("FAIL rstmid_issue got en=%b addr=%h want 1/00000700", mem_en, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h77 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resp got rdy=%b rdata=%h err=%b want 1/00000077/0", if_ready, if_rdata, bus_err);
        end
        $display("txn fetch addr=00000700 after mid-access reset");
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_both_request();
        test_streak();
        test_store();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LS_STREAK, default 4: max consecutive LSU grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 15: max WAIT cycles before bus error.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch read request, held with if_addr until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  out  32  fetch data, valid while if_ready=1.
REQ-009 ls_req  in  1  load/store request, held with ls_we/ls_addr/ls_wdata/ls_wstrb until ls_ready.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  32  load/store byte address.
REQ-012 ls_wdata  in  32  store data.
REQ-013 ls_wstrb  in  4  store byte enables.
REQ-014 ls_ready  out  1  one-cycle load/store completion pulse.
REQ-015 ls_rdata  out  32  load data, valid while ls_ready=1; 0 for stores.
REQ-016 bus_err  out  1  with if_ready/ls_ready: access timed out.
REQ-017 mem_en  out  1  one-cycle memory access strobe.
REQ-018 mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  registered memory command, stable from ISSUE until RESP.
REQ-019 mem_ack  in  1  memory completion, one cycle.
REQ-020 mem_rdata  in  32  memory read data, valid with mem_ack.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: no request -> stay; else latch grant and requester command, -> ISSUE.
REQ-023 Grant: LSU wins when both request, unless streak = LS_STREAK, then fetch wins.
REQ-024 Streak counter: +1 on LSU grant with if_req=1; cleared on fetch grant or on LSU grant with if_req=0; saturates at LS_STREAK.
REQ-025 ISSUE: mem_en=1 exactly one cycle; mem_we=1 only for LSU store; fetch forces mem_wstrb=0; -> WAIT.
REQ-026 WAIT: mem_ack=1 -> latch mem_rdata, -> RESP; else increment wait counter.
REQ-027 WAIT: wait counter reaches TIMEOUT without ack -> bus_err, rdata=0, -> RESP.
REQ-028 mem_ack outside WAIT is ignored, including late ack after timeout.
REQ-029 RESP: granted port's ready=1 one cycle, bus_err as determined; -> IDLE; requests not sampled in RESP.
REQ-030 Minimum latency: req at edge 0 -> mem_en cycle 1 -> ack cycle 2 -> ready cycle 3; one access in flight.
REQ-031 Request dropped before ready is a protocol violation; arbiter completes the access and pulses ready regardless.
REQ-032 Ungranted port's ready and rdata stay 0.

Reset
REQ-033 rst=0 at any time: state IDLE; streak and wait counters 0; all outputs 0; in-flight access abandoned with no ready.
REQ-034 rst released mid-access: first grant decision made in IDLE on the next edge; stale mem_ack ignored per REQ-028.

Structure
REQ-035 Package mem_arbiter_pkg: state enum, grant enum (GNT_IF, GNT_LS), default LS_STREAK/TIMEOUT constants.
REQ-036 One sub-module mem_timeout_ctr: loadable down-counter giving expired flag; used by WAIT.

Verification
REQ-037 Fetch only: if_addr=0x100, ack 2 cycles after mem_en, mem_rdata=0x00000013 -> if_ready cycle 4, if_rdata=0x00000013, bus_err=0.
REQ-038 Both request same edge: ls_addr=0x2000 load, if_addr=0x104 -> LSU served first; fetch served on next IDLE.
REQ-039 ls_req held continuous (6 accesses), if_req high throughout -> exactly 4 LSU grants, then 1 fetch grant, then LSU resumes.
REQ-040 Store ls_addr=0x3000, ls_wdata=0xDEADBEEF, ls_wstrb=0x3 -> mem_we=1, mem_wstrb=0x3, ls_rdata=0 at ls_ready.
REQ-041 No mem_ack for 15 WAIT cycles -> ls_ready with bus_err=1, ls_rdata=0; ack injected next cycle ignored; next request served normally.
REQ-042 rst=0 asserted during WAIT -> all outputs 0 immediately; no ready pulse; after release, if_req=1 -> normal access.
